// File: rtl/norm32.sv
// norm32: sequential 32-bit normalizer. A five-stage binary search (16/8/4/2/1)
// shifts the operand left until bit 31 is set and reports the shift count.
module norm32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] d,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic [4:0]  s,
  output logic        z
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t      state, state_next;
  logic [31:0] r, r_next;
  logic [4:0]  c, c_next;
  logic [2:0]  k, k_next;
  logic        busy_next, done_next, z_next;
  logic [31:0] q_next;
  logic [4:0]  s_next;

  // result of the current search stage, before the FSM decides what to keep
  logic [31:0] stage_r;
  logic [4:0]  stage_c;

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      r     <= '0;
      c     <= '0;
      k     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      q     <= '0;
      s     <= '0;
      z     <= 1'b0;
    end else begin
      state <= state_next;
      r     <= r_next;
      c     <= c_next;
      k     <= k_next;
      busy  <= busy_next;
      done  <= done_next;
      q     <= q_next;
      s     <= s_next;
      z     <= z_next;
    end
  end

  // One binary-search stage: shift by w when the top w bits are all zero.
  always_comb begin
    stage_r = r;
    stage_c = c;
    case (k)
      3'd0: if (r[31:16] == '0) begin stage_r = {r[15:0], 16'b0}; stage_c = c + 5'd16; end
      3'd1: if (r[31:24] == '0) begin stage_r = {r[23:0], 8'b0};  stage_c = c + 5'd8;  end
      3'd2: if (r[31:28] == '0) begin stage_r = {r[27:0], 4'b0};  stage_c = c + 5'd4;  end
      3'd3: if (r[31:30] == '0) begin stage_r = {r[29:0], 2'b0};  stage_c = c + 5'd2;  end
      3'd4: if (r[31] == 1'b0)  begin stage_r = {r[30:0], 1'b0};  stage_c = c + 5'd1;  end
      default: ;
    endcase
  end

  // Next-state logic. On the final stage a pending start is taken immediately,
  // so back-to-back operations complete every five cycles.
  always_comb begin
    state_next = state;
    r_next     = r;
    c_next     = c;
    k_next     = k;
    busy_next  = busy;
    done_next  = 1'b0;
    q_next     = q;
    s_next     = s;
    z_next     = z;

    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
          r_next     = d;
          c_next     = '0;
          k_next     = '0;
          busy_next  = 1'b1;
        end
      end
      SHIFT: begin
        r_next = stage_r;
        c_next = stage_c;
        k_next = k + 3'd1;
        if (k == 3'd4) begin
          q_next    = stage_r;
          s_next    = stage_c;
          z_next    = (stage_r == '0);
          done_next = 1'b1;
          if (start) begin
            r_next = d;
            c_next = '0;
            k_next = '0;
          end else begin
            state_next = IDLE;
            busy_next  = 1'b0;
            k_next     = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
